led_sequencer: RTL and testbench

Controller for the board's 16-LED bank, driven by the 16 slide switches on the 100 MHz board clock.
Synchronises and debounces the switches. Decodes sw[15:14] as a display mode and sequences a 14-bit LED pattern on a programmable tick.
Sits between the raw sw/LED pins and the top level; the top instantiates it and routes LED straight to the pins.

---
 rtl/led_seq_pkg.sv | 19 +
 rtl/sw_debounce.sv | 57 +++++
 rtl/led_sequencer.sv | 103 ++++++++++
 tb/tb_led_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and widths for the LED sequencer.
package led_seq_pkg;

  localparam int PAT_W = 14;
  localparam int LED_W = 16;

  typedef enum logic [1:0] {
    PASS  = 2'b00,
    CHASE = 2'b01,
    BLINK = 2'b10,
    COUNT = 2'b11
  } mode_t;

  // Rotate a pattern left by one position; the top bit wraps into bit 0.
  function automatic logic [PAT_W-1:0] rotl1(input logic [PAT_W-1:0] p);
    return {p[PAT_W-2:0], p[PAT_W-1]};
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch synchroniser plus whole-vector debouncer.
// The output only takes a new value once the synchronised vector has been
// sampled unchanged on DEBOUNCE_CYCLES consecutive clock edges.
module sw_debounce #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             CLK100MHZ,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
  logic [WIDTH-1:0]                  sw_s;
  logic [WIDTH-1:0]                  cand;
  logic [CNT_W-1:0]                  cnt;
  logic [CNT_W-1:0]                  cnt_next;

  assign sw_s = sync_chain[SYNC_STAGES-1];

  // Count consecutive identical samples; a fresh value counts as its first sample.
  always_comb begin
    cnt_next = '0;
    if (sw_s != cand) begin
      cnt_next = CNT_W'(1);
    end else if (cnt == CNT_MAX) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // Synchroniser shift, stability tracking and acceptance of the stable vector.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      sync_chain <= '0;
      cand       <= '0;
      cnt        <= '0;
      dout       <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], din};
      cand       <= sw_s;
      cnt        <= cnt_next;
      if (cnt_next == CNT_MAX) begin
        dout <= sw_s;
      end else begin
        dout <= dout;
      end
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// 16-LED bank controller: debounced switches select a display mode
// (sw[15:14]) and the low 14 LEDs are sequenced on a programmable tick.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV        = 10_000_000,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             CLK100MHZ,
  input  logic             rst,
  input  logic [LED_W-1:0] sw,
  output logic [LED_W-1:0] LED,
  output logic             tick
);

  localparam int PR_W = $clog2(TICK_DIV);
  localparam logic [PR_W-1:0] PR_LAST = PR_W'(TICK_DIV - 1);

  logic [LED_W-1:0] sw_db;
  mode_t            mode;
  mode_t            mode_req;
  logic             mode_change;
  logic             at_last;
  logic             tick_ev;
  logic [PR_W-1:0]  presc;
  logic [PAT_W-1:0] pattern;
  logic             blink_on;

  sw_debounce #(
    .WIDTH          (LED_W),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK100MHZ(CLK100MHZ),
    .rst      (rst),
    .din      (sw),
    .dout     (sw_db)
  );

  // Decode the requested mode and the tick event; a mode change suppresses the tick.
  always_comb begin
    mode_req    = mode_t'(sw_db[15:14]);
    mode_change = (mode_req != mode);
    at_last     = (presc == PR_LAST);
    tick_ev     = at_last && !mode_change;
  end

  assign tick = tick_ev;

  // Mode FSM, prescaler, pattern sequencing and the registered LED drive.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      mode     <= PASS;
      presc    <= '0;
      pattern  <= '0;
      blink_on <= 1'b0;
      LED      <= '0;
    end else begin
      LED <= {mode, pattern};
      if (mode_change) begin
        mode     <= mode_req;
        presc    <= '0;
        blink_on <= 1'b1;
        case (mode_req)
          PASS:    pattern <= sw_db[PAT_W-1:0];
          CHASE:   pattern <= PAT_W'(1);
          BLINK:   pattern <= sw_db[PAT_W-1:0];
          COUNT:   pattern <= '0;
          default: pattern <= '0;
        endcase
      end else begin
        if (at_last) begin
          presc <= '0;
        end else begin
          presc <= presc + PR_W'(1);
        end
        case (mode)
          PASS: pattern <= sw_db[PAT_W-1:0];
          CHASE: begin
            if (tick_ev) pattern <= rotl1(pattern);
            else         pattern <= pattern;
          end
          BLINK: begin
            // In the on-phase the pattern tracks the switches live.
            if (tick_ev) begin
              blink_on <= !blink_on;
              pattern  <= blink_on ? '0 : sw_db[PAT_W-1:0];
            end else begin
              pattern  <= blink_on ? sw_db[PAT_W-1:0] : '0;
            end
          end
          COUNT: begin
            if (tick_ev) pattern <= pattern + PAT_W'(sw_db[3:0]);
            else         pattern <= pattern;
          end
          default: pattern <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with a behavioural reference model.
module tb_led_sequencer;

  localparam int TD = 4;
  localparam int SS = 2;
  localparam int DC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw  = 16'h0000;
  logic [15:0] LED;
  logic        tick;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state (values after the most recent clock edge)
  logic [15:0] m_sync[$];
  logic [15:0] m_hist[$];
  logic [15:0] m_db;
  logic [15:0] m_led;
  int          m_mode;
  int          m_presc;
  int          m_pat;
  bit          m_on;

  led_sequencer #(
    .TICK_DIV       (TD),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .CLK100MHZ(clk),
    .rst      (rst),
    .sw       (sw),
    .LED      (LED),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  function automatic bit m_tick();
    return (m_presc == TD - 1) && (int'(m_db[15:14]) == m_mode);
  endfunction

  // Advance the model over one rising edge given the inputs seen at that edge.
  task automatic model_edge(input logic [15:0] sw_v, input logic rst_v);
    logic [15:0] s;
    logic [15:0] new_db;
    logic [15:0] new_led;
    int req;
    int low;
    bit tk;
    bit all_eq;
    if (rst_v) begin
      m_sync.delete();
      for (int i = 0; i < SS; i++) m_sync.push_back(16'h0000);
      m_hist.delete();
      m_db = 16'h0000; m_mode = 0; m_presc = 0; m_pat = 0; m_on = 1'b1; m_led = 16'h0000;
    end else begin
      new_led = 16'(m_mode * 16384 + m_pat);
      s = m_sync.pop_front();
      m_sync.push_back(sw_v);
      m_hist.push_back(s);
      if (m_hist.size() > DC) void'(m_hist.pop_front());
      new_db = m_db;
      if (m_hist.size() == DC) begin
        all_eq = 1'b1;
        foreach (m_hist[i]) if (m_hist[i] !== s) all_eq = 1'b0;
        if (all_eq) new_db = s;
      end
      req = int'(m_db[15:14]);
      low = int'(m_db[13:0]);
      tk  = (m_presc == TD - 1);
      if (req != m_mode) begin
        m_mode = req; m_presc = 0; m_on = 1'b1;
        m_pat = (req == 1) ? 1 : (req == 3) ? 0 : low;
      end else begin
        m_presc = (m_presc + 1) % TD;
        if (m_mode == 0) m_pat = low;
        else if (m_mode == 1) begin
          if (tk) m_pat = ((m_pat * 2) % 16384) + (m_pat / 8192);
        end else if (m_mode == 2) begin
          if (tk) m_on = !m_on;
          m_pat = m_on ? low : 0;
        end else begin
          if (tk) m_pat = (m_pat + int'(m_db[3:0])) % 16384;
        end
      end
      m_db  = new_db;
      m_led = new_led;
    end
  endtask

  // One clock: inputs sampled at the rising edge, outputs observed at the falling edge.
  task automatic cycle();
    logic [15:0] sw_v;
    logic        rst_v;
    sw_v = sw; rst_v = rst;
    @(posedge clk);
    model_edge(sw_v, rst_v);
    @(negedge clk);
  endtask

  task automatic wait_tick(output bit ok);
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 12) begin cycle(); n++; end
    ok = (tick === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      cycle();
      total_cnt++;
      if (LED !== 16'h0000 || tick !== 1'b0)
        $display("FAIL reset LED=%h tick=%b expected LED=0000 tick=0", LED, tick);
      else pass_cnt++;
    end
  endtask

  task automatic test_pass_latency();
    int lat;
    int ticks;
    rst = 1'b0; sw = 16'h0A5A; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      total_cnt++;
      if (LED !== m_led || tick !== m_tick())
        $display("FAIL pass_model LED=%h tick=%b expected LED=%h tick=%b", LED, tick, m_led, m_tick());
      else pass_cnt++;
      if (LED === 16'h0A5A && lat == 0) lat = i;
    end
    total_cnt++;
    if (lat != 7) $display("FAIL pass_latency got=%0d expected=7", lat);
    else pass_cnt++;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (tick === 1'b1) ticks++;
    end
    total_cnt++;
    if (ticks != 3) $display("FAIL tick_period got=%0d ticks expected=3", ticks);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    sw = 16'h0000;
    for (int i = 0; i < 10; i++) cycle();
    sw = 16'h0001; cycle(); cycle();
    sw = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      cycle();
      total_cnt++;
      if (LED !== 16'h0000 || LED !== m_led)
        $display("FAIL glitch_reject LED=%h expected=0000", LED);
      else pass_cnt++;
    end
    sw = 16'h0001;
    for (int i = 0; i < 10; i++) cycle();
    total_cnt++;
    if (LED !== 16'h0001) $display("FAIL glitch_accept LED=%h expected=0001", LED);
    else pass_cnt++;
  endtask

  task automatic test_chase();
    bit ok;
    logic [15:0] exp;
    int n;
    sw = 16'h4000; n = 0;
    while (LED !== 16'h4001 && n < 20) begin cycle(); n++; end
    total_cnt++;
    if (LED !== 16'h4001) $display("FAIL chase_enter LED=%h expected=4001", LED);
    else pass_cnt++;
    for (int k = 1; k <= 14; k++) begin
      wait_tick(ok);
      cycle(); cycle();
      exp = (k == 14) ? 16'h4001 : (16'h4000 | (16'd1 << k));
      total_cnt++;
      if (!ok || LED !== exp || LED !== m_led)
        $display("FAIL chase_step%0d LED=%h expected=%h tick_seen=%0d", k, LED, exp, ok);
      else pass_cnt++;
    end
  endtask

  task automatic test_blink();
    bit ok;
    int n;
    logic [15:0] exp;
    sw = 16'h8F0F; n = 0;
    while (LED !== 16'h8F0F && n < 20) begin cycle(); n++; end
    total_cnt++;
    if (LED !== 16'h8F0F) $display("FAIL blink_enter LED=%h expected=8F0F", LED);
    else pass_cnt++;
    for (int k = 1; k <= 4; k++) begin
      wait_tick(ok);
      cycle(); cycle();
      exp = (k % 2 == 1) ? 16'h8000 : 16'h8F0F;
      total_cnt++;
      if (!ok || LED !== exp) $display("FAIL blink_toggle%0d LED=%h expected=%h", k, LED, exp);
      else pass_cnt++;
    end
    sw = 16'h8000;
    for (int i = 0; i < 10; i++) cycle();
    for (int i = 0; i < 16; i++) begin
      cycle();
      total_cnt++;
      if (LED !== 16'h8000 || LED !== m_led) $display("FAIL blink_dark LED=%h expected=8000", LED);
      else pass_cnt++;
    end
  endtask

  task automatic test_count();
    bit ok;
    int n;
    logic [15:0] exp;
    sw = 16'hC005; n = 0;
    while (LED !== 16'hC000 && n < 20) begin cycle(); n++; end
    total_cnt++;
    if (LED !== 16'hC000) $display("FAIL count_enter LED=%h expected=C000", LED);
    else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      wait_tick(ok);
      cycle(); cycle();
      exp = 16'hC000 | 16'(5 * k);
      total_cnt++;
      if (!ok || LED !== exp) $display("FAIL count_step%0d LED=%h expected=%h", k, LED, exp);
      else pass_cnt++;
    end
    // Run up close to the top of the range with a large step, then finish with step 1.
    sw = 16'hC00F; n = 0;
    while (m_pat < 16322 && n < 6000) begin
      cycle(); n++;
      total_cnt++;
      if (LED !== m_led) $display("FAIL count_run LED=%h expected=%h", LED, m_led);
      else pass_cnt++;
    end
    sw = 16'hC001; n = 0;
    while (m_pat != 16382 && n < 600) begin cycle(); n++; end
    total_cnt++;
    if (m_pat != 16382) $display("FAIL count_approach model=%0d expected=16382", m_pat);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (LED !== 16'hFFFE) $display("FAIL count_16382 LED=%h expected=FFFE", LED);
    else pass_cnt++;
    wait_tick(ok); cycle(); cycle();
    total_cnt++;
    if (!ok || LED !== 16'hFFFF) $display("FAIL count_16383 LED=%h expected=FFFF", LED);
    else pass_cnt++;
    wait_tick(ok); cycle(); cycle();
    total_cnt++;
    if (!ok || LED !== 16'hC000) $display("FAIL count_wrap LED=%h expected=C000", LED);
    else pass_cnt++;
    sw = 16'hC000;
    for (int i = 0; i < 10; i++) cycle();
    exp = m_led;
    for (int i = 0; i < 20; i++) begin
      cycle();
      total_cnt++;
      if (LED !== exp || m_led !== exp) $display("FAIL count_hold LED=%h expected=%h", LED, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_mode_tick();
    int n;
    bit exp_t;
    n = 0;
    while (m_presc != 2 && n < 8) begin cycle(); n++; end
    sw = 16'h4000;
    for (int k = 1; k <= 11; k++) begin
      cycle();
      if (k <= 9) begin
        exp_t = (k == 1 || k == 9);
        total_cnt++;
        if (tick !== exp_t) $display("FAIL modetick_tick%0d tick=%b expected=%b", k, tick, exp_t);
        else pass_cnt++;
      end
      if (k == 7 || k == 9) begin
        total_cnt++;
        if (LED !== 16'h4001) $display("FAIL modetick_init%0d LED=%h expected=4001", k, LED);
        else pass_cnt++;
      end
      if (k == 11) begin
        total_cnt++;
        if (LED !== 16'h4002) $display("FAIL modetick_rot LED=%h expected=4002", LED);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_mid_reset();
    sw = 16'hC003;
    for (int i = 0; i < 20; i++) cycle();
    rst = 1'b1; cycle();
    total_cnt++;
    if (LED !== 16'h0000 || tick !== 1'b0) $display("FAIL midreset LED=%h tick=%b expected LED=0000 tick=0", LED, tick);
    else pass_cnt++;
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      total_cnt++;
      if (LED !== ((k == 7) ? 16'hC000 : 16'h0000) || LED !== m_led)
        $display("FAIL midreset_resume%0d LED=%h model=%h", k, LED, m_led);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        sw   = 16'($urandom);
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(4, 14));
      end
      hold--;
      cycle();
      total_cnt++;
      if (LED !== m_led || tick !== m_tick())
        $display("FAIL random_model LED=%h tick=%b expected LED=%h tick=%b", LED, tick, m_led, m_tick());
      else pass_cnt++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pass_latency();
    test_glitch();
    test_chase();
    test_blink();
    test_count();
    test_mode_tick();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
